// File: rtl/phy_sched_pkg.sv
// Shared types for the phy_pipeline scheduler: FSM encoding,
// return-tag layout {valid,last,id} and the default pipeline latency.
package phy_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int PIPE_LAT_DEF = 4;
    localparam int TAG_META_W   = 2;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Tag: [W-1] valid, [W-2] last, [ID_W-1:0] id
    function automatic int tag_width(input int n_req);
        return id_width(n_req) + TAG_META_W;
    endfunction

endpackage

// File: rtl/phy_tag_delay.sv
// Width x depth shift register with async active-high reset, for
// labelling the output of any fixed-latency PHY stage.
module phy_tag_delay #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/phy_pipe_scheduler.sv
// Burst-granular round-robin front/back end for a shared phy_pipeline.
// Optional per-requester burst statistics: define PHY_SCHED_STATS_EN.
module phy_pipe_scheduler
    import phy_sched_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  DATA_W    = 16,
    parameter int  PIPE_LAT  = PIPE_LAT_DEF,
    parameter int  MAX_BURST = 64,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    pipe_valid,
    output logic [DATA_W-1:0]       pipe_data_in,
    input  logic [DATA_W-1:0]       pipe_data_out,
    output logic                    out_valid,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_last,
    output logic [DATA_W-1:0]       out_data,
    output logic                    busy,
`ifdef PHY_SCHED_STATS_EN
    input  logic [ID_W-1:0]         stat_sel,
    output logic [15:0]             stat_bursts,
`endif
    output logic                    burst_trunc
);

    localparam int CNT_W = $clog2(MAX_BURST);
    localparam int TAG_W = tag_width(N_REQ);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              pvalid_q, pvalid_d;
    logic              plast_q, plast_d;
    logic [ID_W-1:0]   pid_q, pid_d;
    logic              trunc_q, trunc_d;

    logic              g_valid, g_last, accept, at_max, b_end;
    logic [DATA_W-1:0] g_data;
    logic [ID_W:0]     pick;
    logic [TAG_W-1:0]  tag_in, tag_out;

    // First valid requester after p, wrapping; MSB flags a hit.
    function automatic logic [ID_W:0] rr_pick(
        input logic [N_REQ-1:0] v,
        input logic [ID_W-1:0]  p
    );
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(p) + k) % N_REQ;
            if (v[idx]) begin
                r = {1'b1, ID_W'(idx)};
            end
        end
        return r;
    endfunction

    assign pick    = rr_pick(req_valid, ptr_q);
    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign accept  = (state_q == BURST) && g_valid;
    assign at_max  = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign b_end   = accept && (g_last || at_max);

    always_comb begin
        req_ready = '0;
        if (state_q == BURST) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        pvalid_d = accept;
        pdata_d  = accept ? g_data : pdata_q;
        plast_d  = b_end;
        pid_d    = accept ? grant_q : '0;
        trunc_d  = b_end && !g_last;
        unique case (state_q)
            IDLE: begin
                if (sched_en && pick[ID_W]) begin
                    grant_d = pick[ID_W-1:0];
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (b_end) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= ID_W'(N_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
            plast_q  <= 1'b0;
            pid_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            plast_q  <= plast_d;
            pid_q    <= pid_d;
            trunc_q  <= trunc_d;
        end
    end

    // Tag rides the registered beat so it lines up with data_out.
    assign tag_in = {pvalid_q, plast_q, pid_q};

    phy_tag_delay #(
        .W     (TAG_W),
        .DEPTH (PIPE_LAT)
    ) u_tag_delay (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (tag_in),
        .q_o   (tag_out)
    );

    assign out_valid    = tag_out[TAG_W-1];
    assign out_last     = tag_out[TAG_W-2];
    assign out_id       = tag_out[ID_W-1:0];
    assign out_data     = out_valid ? pipe_data_out : '0;
    assign pipe_valid   = pvalid_q;
    assign pipe_data_in = pdata_q;
    assign busy         = (state_q == BURST);
    assign burst_trunc  = trunc_q;

`ifdef PHY_SCHED_STATS_EN
    logic [15:0] bursts_q [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                bursts_q[i] <= '0;
            end
        end else if (b_end && (bursts_q[grant_q] != 16'hFFFF)) begin
            bursts_q[grant_q] <= bursts_q[grant_q] + 16'd1;
        end
    end

    assign stat_bursts = bursts_q[stat_sel];
`endif

endmodule

// File: tb/tb_phy_pipe_scheduler.sv
// Bench for phy_pipe_scheduler: directed scenarios plus randomized
// bursts, checked against a transaction-level round-robin model.
module tb_phy_pipe_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int MB = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sched_en = 1'b1;
    logic [N-1:0]  req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic          pipe_valid, out_valid, out_last, busy, burst_trunc;
    logic [DW-1:0] pipe_data_in, pipe_data_out, out_data;
    logic [1:0]    out_id;

    always #5 clk = ~clk;

    phy_pipe_scheduler #(
        .N_REQ(N), .DATA_W(DW), .PIPE_LAT(L), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .pipe_valid(pipe_valid),
        .pipe_data_in(pipe_data_in), .pipe_data_out(pipe_data_out),
        .out_valid(out_valid), .out_id(out_id), .out_last(out_last),
        .out_data(out_data), .busy(busy), .burst_trunc(burst_trunc)
    );

    // phy_pipeline stand-in: L cycles, bitwise inversion
    logic [DW-1:0] pl [L];
    always @(posedge clk) begin
        pl[0] <= pipe_data_in;
        for (int i = 1; i < L; i++) pl[i] <= pl[i-1];
    end
    assign pipe_data_out = ~pl[L-1];

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [1:0] id; logic last; logic [DW-1:0] data; } ret_t;
    typedef struct packed { logic [DW-1:0] data; logic trunc; } pip_t;

    beat_t dq [N][$];
    beat_t mq [N][$];
    ret_t  exp_out [$];
    pip_t  exp_pipe [$];
    int    mptr = N - 1;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 0, rbub = 0, log_en = 0;
    int    hold_end [N] = '{default: 0};
    int    acc_cnt [N] = '{default: 0};
    int    pv_cyc [$];
    int    ov_cyc [$];
    pip_t  mp;
    ret_t  mr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester drivers: valid while data pending, bubbles only when granted
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            for (int i = 0; i < N; i++) if (acc[i]) acc_cnt[i]++;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
                if (cyc < hold_end[i])
                    req_valid[i] = 1'b0;
                else
                    req_valid[i] = (dq[i].size() > 0) &&
                        !(req_ready[i] && rbub && $urandom_range(3) == 0);
                if (dq[i].size() > 0) begin
                    req_data[i*DW +: DW] = dq[i][0].data;
                    req_last[i] = dq[i][0].last;
                end else begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
        end
    end

    // Reference: grant the next pending requester after the last winner,
    // take beats until a real last or the MB-th beat.
    function automatic void predict();
        int g, n;
        bit e;
        beat_t b;
        ret_t r;
        pip_t p;
        while (1) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && mq[(mptr + k) % N].size() > 0) g = (mptr + k) % N;
            if (g < 0) return;
            n = 0;
            do begin
                b = mq[g].pop_front();
                n++;
                e = b.last || (n == MB);
                r.id = 2'(g);
                r.last = e;
                r.data = ~b.data;
                exp_out.push_back(r);
                p.data = b.data;
                p.trunc = (n == MB) && !b.last;
                exp_pipe.push_back(p);
            end while (!e);
            mptr = g;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (pipe_valid) begin
                if (log_en) pv_cyc.push_back(cyc);
                if (exp_pipe.size() == 0) check("pipe_unexpected", pipe_valid, 0);
                else begin
                    mp = exp_pipe.pop_front();
                    check("pipe_data", pipe_data_in, mp.data);
                    check("burst_trunc", burst_trunc, mp.trunc);
                end
            end else if (burst_trunc) check("trunc_no_valid", burst_trunc, pipe_valid);
            if (out_valid) begin
                if (log_en) ov_cyc.push_back(cyc);
                if (exp_out.size() == 0) check("out_unexpected", out_valid, 0);
                else begin
                    mr = exp_out.pop_front();
                    check("out_id", out_id, mr.id);
                    check("out_last", out_last, mr.last);
                    check("out_data", out_data, mr.data);
                end
            end
        end
    end

    task automatic add_beat(input int i, input logic [DW-1:0] d, input bit last,
                            input bit model);
        beat_t b;
        b.data = d;
        b.last = last;
        dq[i].push_back(b);
        if (model) mq[i].push_back(b);
    endtask

    task automatic add_burst(input int i, input int len, input bit model);
        for (int k = 0; k < len; k++)
            add_beat(i, DW'($urandom), k == len - 1, model);
    endtask

    task automatic drain(input int budget, input bit rnd_en);
        int n = 0;
        bit pend = 1;
        while (pend && n < budget) begin
            if (rnd_en) sched_en = ($urandom_range(3) != 0);
            @(negedge clk);
            n++;
            pend = (exp_out.size() > 0) || (exp_pipe.size() > 0);
            for (int i = 0; i < N; i++) if (dq[i].size() > 0) pend = 1;
        end
        sched_en = 1'b1;
        check("drain_in_budget", 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mptr = N - 1;
        pv_cyc.delete();
        ov_cyc.delete();
    endtask

    task automatic wait_acc(input int i, input int target, input string tag);
        int n = 0;
        while (acc_cnt[i] < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(acc_cnt[i] >= target), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pipe_valid"}, pipe_valid, 0);
        check({tag, "_pipe_data"}, pipe_data_in, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_id"}, out_id, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_trunc"}, burst_trunc, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v, base, c, len, nb;

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // A: single requester, 4 fixed beats
        mon_en = 1;
        log_en = 1;
        @(negedge clk);
        v = cyc + 1;
        add_beat(0, 16'h1234, 0, 1);
        add_beat(0, 16'hABCD, 0, 1);
        add_beat(0, 16'h0000, 0, 1);
        add_beat(0, 16'hFFFF, 1, 1);
        predict();
        drain(200, 0);
        check("A_pv_count", pv_cyc.size(), 4);
        check("A_pv_first", pv_cyc[0], v + 2);
        check("A_pv_last", pv_cyc[3], v + 5);
        check("A_ov_first", ov_cyc[0], v + 2 + L);

        // B: all requesters, 3-beat bursts, order 0,1,2,3,0
        do_reset();
        add_burst(0, 3, 1);
        add_burst(0, 3, 1);
        for (int i = 1; i < N; i++) add_burst(i, 3, 1);
        predict();
        drain(300, 0);
        check("B_pv_count", pv_cyc.size(), 15);
        check("B_span", pv_cyc[14] - pv_cyc[0], 18);
        check("B_latency", ov_cyc[0] - pv_cyc[0], L);

        // C: truncation at MB, then requester 3, then 2 again
        do_reset();
        add_burst(2, 70, 1);
        add_burst(3, 2, 1);
        predict();
        drain(500, 0);
        add_burst(2, 66, 1);
        predict();
        drain(500, 0);

        // D: grant held through a 3-cycle valid gap on requester 1
        do_reset();
        base = acc_cnt[1];
        add_burst(1, 8, 1);
        predict();
        wait_acc(1, base + 1, "D_grant1");
        add_burst(0, 4, 1);
        predict();
        wait_acc(1, base + 2, "D_beat2");
        hold_end[1] = cyc + 4;
        drain(300, 0);
        check("D_pv_count", pv_cyc.size(), 12);
        check("D_span1", pv_cyc[7] - pv_cyc[0], 10);
        check("D_idle_gap", pv_cyc[8] - pv_cyc[7], 2);

        // E: sched_en dropped mid-burst
        do_reset();
        base = acc_cnt[0];
        add_burst(0, 5, 1);
        predict();
        wait_acc(0, base + 1, "E_start");
        sched_en = 1'b0;
        add_burst(1, 3, 1);
        add_burst(2, 3, 1);
        wait_acc(0, base + 5, "E_complete");
        repeat (6) @(negedge clk);
        check("E_hold_busy", busy, 0);
        check("E_hold_ready", req_ready, 0);
        check("E_hold_pipe", pipe_valid, 0);
        predict();
        sched_en = 1'b1;
        @(negedge clk);
        check("E_resume_busy", busy, 1);
        check("E_resume_ready", req_ready, 4'b0010);
        drain(300, 0);

        // F: reset mid-burst drops in-flight beats
        do_reset();
        mon_en = 0;
        base = acc_cnt[1];
        add_burst(1, 10, 0);
        wait_acc(1, base + 4, "F_inflight");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("midrst");
        dq[1].delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        mptr = N - 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("F_no_out", out_valid, 0);
        end
        mon_en = 1;
        pv_cyc.delete();
        ov_cyc.delete();
        add_burst(2, 3, 1);
        add_burst(0, 3, 1);
        predict();
        drain(300, 0);
        check("F_first_is_0", exp_out.size(), 0);

        // R: randomized bursts with bubbles and sched_en toggling
        log_en = 0;
        rbub = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    c = $urandom_range(3);
                    if (c == 0) len = MB;
                    else if (c == 1) len = $urandom_range(1, 8);
                    else len = $urandom_range(1, 140);
                    add_burst(i, len, 1);
                end
            end
            predict();
            drain(6000, 1);
        end
        rbub = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
